uart_tx_arbiter: RTL and testbench

- Round-robin packet arbiter that shares one UART transmit path among NUM_REQ requesters.
- The transmit path is the TX byte FIFO (socetlib_fifo write side) feeding UartTxEn.
- Grants whole packets, delimited by req_last. Forces release after MAX_PKT bytes, or when the owner stalls for STALL_TIMEOUT cycles.
- Sits between peripheral/bus-side byte producers and the TX FIFO in the AHB UART subsystem.

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin packet arbiter that shares one UART TX byte FIFO among
//   NUM_REQ byte producers. A grant covers a whole packet, delimited by
//   req_last. The grant is also released after MAX_PKT bytes, or after
//   STALL_TIMEOUT consecutive cycles in which the owner offers no byte.
//
// Ports
//   clk, nReset            clock (rising edge), asynchronous active-low reset
//   req_valid/data/last    per-requester byte stream (byte i at [8i+7:8i])
//   req_ready              per-requester accept (only the owner, only when not full)
//   fifo_wen/fifo_wdata    TX FIFO write side (wdata forced to 0 when not writing)
//   fifo_full              TX FIFO back-pressure
//   grant_active/grant_id  ownership status; grant_id keeps the most recent owner
//   pkt_done/trunc/abort   one-cycle pulse after a release: normal end,
//                          MAX_PKT limit, stall timeout
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_PKT       = 16,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       nReset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_wen,
    output logic [7:0]                 fifo_wdata,
    input  logic                       fifo_full,
    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       pkt_done,
    output logic                       pkt_trunc,
    output logic                       pkt_abort
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_PKT + 1);
    localparam int SCW = $clog2(STALL_TIMEOUT + 1);

    localparam logic [BCW-1:0] BYTE_LIMIT  = BCW'(MAX_PKT);
    localparam logic [SCW-1:0] STALL_LIMIT = SCW'(STALL_TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg,     state_next;
    logic [IDW-1:0]   grant_id_reg,  grant_id_next;
    logic [IDW-1:0]   last_ptr_reg,  last_ptr_next;
    logic [BCW-1:0]   byte_cnt_reg,  byte_cnt_next;
    logic [SCW-1:0]   stall_cnt_reg, stall_cnt_next;
    logic             done_reg,      done_next;
    logic             trunc_reg,     trunc_next;
    logic             abort_reg,     abort_next;

    logic [7:0]       req_byte [NUM_REQ];
    logic             busy;
    logic             owner_valid;
    logic             owner_last;
    logic             xfer;

    // First valid requester scanning upward from last+1, wrapping at NUM_REQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDW-1:0]     last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign busy        = (state_reg == BUSY);
    assign owner_valid = req_valid[grant_id_reg];
    assign owner_last  = req_last[grant_id_reg];
    assign xfer        = busy && owner_valid && !fifo_full;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_byte[gi]  = req_data[8*gi +: 8];
            assign req_ready[gi] = busy && (grant_id_reg == IDW'(gi)) && !fifo_full;
        end
    endgenerate

    assign fifo_wen     = xfer;
    assign fifo_wdata   = xfer ? req_byte[grant_id_reg] : 8'h00;
    assign grant_active = busy;
    assign grant_id     = grant_id_reg;
    assign pkt_done     = done_reg;
    assign pkt_trunc    = trunc_reg;
    assign pkt_abort    = abort_reg;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg     <= IDLE;
            grant_id_reg  <= '0;
            last_ptr_reg  <= IDW'(NUM_REQ - 1);
            byte_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            done_reg      <= 1'b0;
            trunc_reg     <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_id_reg  <= grant_id_next;
            last_ptr_reg  <= last_ptr_next;
            byte_cnt_reg  <= byte_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            done_reg      <= done_next;
            trunc_reg     <= trunc_next;
            abort_reg     <= abort_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_id_next  = grant_id_reg;
        last_ptr_next  = last_ptr_reg;
        byte_cnt_next  = byte_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        done_next      = 1'b0;
        trunc_next     = 1'b0;
        abort_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    state_next     = BUSY;
                    grant_id_next  = rr_pick(req_valid, last_ptr_reg);
                    byte_cnt_next  = '0;
                    stall_cnt_next = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    stall_cnt_next = '0;
                    if (byte_cnt_reg != BYTE_LIMIT)
                        byte_cnt_next = byte_cnt_reg + BCW'(1);
                    // req_last wins over the size limit on the same byte.
                    if (owner_last)
                        done_next = 1'b1;
                    else if (byte_cnt_reg + BCW'(1) == BYTE_LIMIT)
                        trunc_next = 1'b1;
                end else if (!owner_valid) begin
                    // Only an absent owner counts as a stall; a byte held
                    // back by fifo_full leaves the stall count untouched.
                    if (stall_cnt_reg != STALL_LIMIT)
                        stall_cnt_next = stall_cnt_reg + SCW'(1);
                    if (stall_cnt_reg + SCW'(1) == STALL_LIMIT)
                        abort_next = 1'b1;
                end
                if (done_next || trunc_next || abort_next) begin
                    state_next    = IDLE;
                    last_ptr_next = grant_id_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int MAXP = 16;
    localparam int STO  = 64;

    logic             clk = 1'b0;
    logic             nReset;
    logic [N-1:0]     req_valid, req_last, req_ready;
    logic [N*8-1:0]   req_data;
    logic             fifo_wen;
    logic [7:0]       fifo_wdata;
    logic             fifo_full;
    logic             grant_active;
    logic [1:0]       grant_id;
    logic             pkt_done, pkt_trunc, pkt_abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT(MAXP), .STALL_TIMEOUT(STO)) dut (
        .clk(clk), .nReset(nReset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
        .fifo_full(fifo_full), .grant_active(grant_active), .grant_id(grant_id),
        .pkt_done(pkt_done), .pkt_trunc(pkt_trunc), .pkt_abort(pkt_abort)
    );

    int n_err = 0;
    int n_chk = 0;
    bit verbose = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 60)
                $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the path, how many bytes/idle cycles the
    // current grant has seen, and which end-of-grant pulse is showing now.
    int m_owner;   // -1 means nobody owns the path
    int m_gid, m_last, m_bytes, m_stall;
    bit m_done, m_trunc, m_abort;

    function automatic void model_reset();
        m_owner = -1; m_gid = 0; m_last = N - 1;
        m_bytes = 0; m_stall = 0;
        m_done = 0; m_trunc = 0; m_abort = 0;
    endfunction

    task automatic model_check();
        logic [N-1:0] e_ready;
        logic         e_wen;
        logic [7:0]   e_wdata;
        e_ready = '0; e_wen = 1'b0; e_wdata = 8'h00;
        if (nReset && m_owner >= 0) begin
            if (!fifo_full) e_ready[m_owner] = 1'b1;
            e_wen = req_valid[m_owner] && !fifo_full;
            if (e_wen) e_wdata = req_data[m_owner*8 +: 8];
        end
        check("req_ready",    32'(req_ready),    32'(e_ready));
        check("fifo_wen",     32'(fifo_wen),     32'(e_wen));
        check("fifo_wdata",   32'(fifo_wdata),   32'(e_wdata));
        check("grant_active", 32'(grant_active), 32'(m_owner >= 0));
        check("grant_id",     32'(grant_id),     32'(m_gid));
        check("pkt_done",     32'(pkt_done),     32'(m_done));
        check("pkt_trunc",    32'(pkt_trunc),    32'(m_trunc));
        check("pkt_abort",    32'(pkt_abort),    32'(m_abort));
    endtask

    function automatic void model_step();
        bit found, ended;
        int idx;
        m_done = 0; m_trunc = 0; m_abort = 0;
        ended = 0;
        if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1; m_owner = idx;
                end
            end
            if (found) begin
                m_gid = m_owner; m_bytes = 0; m_stall = 0;
            end
        end else if (req_valid[m_owner] && !fifo_full) begin
            m_bytes++; m_stall = 0;
            if (req_last[m_owner]) begin m_done = 1; ended = 1; end
            else if (m_bytes == MAXP) begin m_trunc = 1; ended = 1; end
        end else if (!req_valid[m_owner]) begin
            m_stall++;
            if (m_stall == STO) begin m_abort = 1; ended = 1; end
        end
        if (ended) begin
            m_last = m_owner; m_owner = -1;
        end
    endfunction

    // Samples taken on the falling edge of the most recent cycle.
    logic [N-1:0] s_acc, s_ready;
    logic         s_wen, s_active, s_done, s_trunc, s_abort;
    logic [7:0]   s_wdata;
    logic [1:0]   s_gid;

    task automatic cycle();
        @(negedge clk);
        s_acc = req_valid & req_ready; s_ready = req_ready;
        s_wen = fifo_wen; s_wdata = fifo_wdata; s_active = grant_active;
        s_gid = grant_id; s_done = pkt_done; s_trunc = pkt_trunc; s_abort = pkt_abort;
        model_check();
        if (verbose && (s_done || s_trunc || s_abort))
            $display("t=%0t grant end id=%0d done=%0d trunc=%0d abort=%0d",
                     $time, s_gid, s_done, s_trunc, s_abort);
        if (nReset) model_step();
        else        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nReset = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        model_reset();
        repeat (2) cycle();
        nReset = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]   valid;
        logic [N*8-1:0] data;
        logic [N-1:0]   last;
        logic           full;
        logic [N-1:0]   e_ready;
        logic           e_wen;
        logic [7:0]     e_wdata;
        logic           e_active;
        logic [1:0]     e_gid;
        logic [2:0]     e_pulse;   // {done, trunc, abort}
    } vec_t;

    function automatic vec_t mk(logic [N-1:0] v, logic [N*8-1:0] d, logic [N-1:0] l, logic f,
                                logic [N-1:0] r, logic w, logic [7:0] wd, logic a,
                                logic [1:0] g, logic [2:0] p);
        vec_t t;
        t.valid = v; t.data = d; t.last = l; t.full = f; t.e_ready = r; t.e_wen = w;
        t.e_wdata = wd; t.e_active = a; t.e_gid = g; t.e_pulse = p;
        return t;
    endfunction

    vec_t vt [10];
    int   ids [$];
    logic [7:0] got [$];
    int   idx, done_n, trunc_n, abort_n, wen_n, trunc_at, last_xfer_c, abort_c, grant1_c;
    bit   prev_wen, back2back, g1_seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nReset = 1'b0;
        do_reset();

        // ---- Table: single packet from requester 2, then a grant under fifo_full ----
        vt[0] = mk(4'b0100, 32'h0041_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 3'b000);
        vt[1] = mk(4'b0100, 32'h0041_0000, 4'b0000, 0, 4'b0100, 1, 8'h41, 1, 2'd2, 3'b000);
        vt[2] = mk(4'b0100, 32'h0042_0000, 4'b0000, 0, 4'b0100, 1, 8'h42, 1, 2'd2, 3'b000);
        vt[3] = mk(4'b0100, 32'h0043_0000, 4'b0100, 0, 4'b0100, 1, 8'h43, 1, 2'd2, 3'b000);
        vt[4] = mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd2, 3'b100);
        vt[5] = mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd2, 3'b000);
        vt[6] = mk(4'b0001, 32'h0000_005A, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 2'd2, 3'b000);
        vt[7] = mk(4'b0001, 32'h0000_005A, 4'b0000, 1, 4'b0000, 0, 8'h00, 1, 2'd0, 3'b000);
        vt[8] = mk(4'b0001, 32'h0000_005A, 4'b0001, 0, 4'b0001, 1, 8'h5A, 1, 2'd0, 3'b000);
        vt[9] = mk(4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd0, 3'b100);
        for (int i = 0; i < 10; i++) begin
            req_valid = vt[i].valid; req_data = vt[i].data;
            req_last = vt[i].last; fifo_full = vt[i].full;
            cycle();
            check($sformatf("tbl%0d_ready", i),  32'(s_ready),  32'(vt[i].e_ready));
            check($sformatf("tbl%0d_wen", i),    32'(s_wen),    32'(vt[i].e_wen));
            check($sformatf("tbl%0d_wdata", i),  32'(s_wdata),  32'(vt[i].e_wdata));
            check($sformatf("tbl%0d_active", i), 32'(s_active), 32'(vt[i].e_active));
            check($sformatf("tbl%0d_gid", i),    32'(s_gid),    32'(vt[i].e_gid));
            check($sformatf("tbl%0d_pulse", i),  32'({s_done, s_trunc, s_abort}), 32'(vt[i].e_pulse));
        end

        // ---- Round robin: everyone sends 1-byte packets ----
        do_reset();
        req_valid = 4'hF; req_last = 4'hF; req_data = 32'hD3D2_D1D0;
        ids.delete(); done_n = 0; prev_wen = 0; back2back = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (s_wen) ids.push_back(int'(s_gid));
            if (s_wen && prev_wen) back2back = 1;
            prev_wen = s_wen;
            if (c <= 8 && s_done) done_n++;
        end
        check("rr_grants", 32'(ids.size()), 32'd5);
        for (int i = 0; i < ids.size() && i < 5; i++)
            check($sformatf("rr_order%0d", i), 32'(ids[i]), 32'(i % N));
        check("rr_done_count", 32'(done_n), 32'd4);
        check("rr_idle_gap", 32'(back2back), 32'd0);
        req_valid = '0; req_last = '0;
        repeat (2) cycle();

        // ---- Back-pressure on requester 1 ----
        do_reset();
        idx = 0; got.delete(); done_n = 0; abort_n = 0;
        for (int c = 0; c < 30; c++) begin
            req_valid = (idx < 4) ? 4'b0010 : 4'b0000;
            req_data  = {16'h0, 8'(16 + idx), 8'h0};
            req_last  = (idx == 3) ? 4'b0010 : 4'b0000;
            fifo_full = (c >= 2 && c <= 5);
            cycle();
            if (fifo_full) begin
                check("bp_ready_full", 32'(s_ready[1]), 32'd0);
                check("bp_wen_full", 32'(s_wen), 32'd0);
            end
            if (s_acc[1]) idx++;
            if (s_wen) got.push_back(s_wdata);
            if (s_done) done_n++;
            if (s_abort) abort_n++;
            if (s_done) break;
        end
        fifo_full = 1'b0;
        check("bp_bytes", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++)
            check($sformatf("bp_byte%0d", i), 32'(got[i]), 32'(16 + i));
        check("bp_done", 32'(done_n), 32'd1);
        // Owner keeps offering a byte while the FIFO stays full for 100+ cycles.
        req_valid = 4'b0010; req_last = '0; req_data = 32'h0000_2000; fifo_full = 1'b1;
        abort_n = 0; wen_n = 0;
        for (int c = 0; c < 101; c++) begin
            cycle();
            if (s_abort || s_trunc || s_done) abort_n++;
            if (s_wen) wen_n++;
        end
        check("bp_no_abort", 32'(abort_n), 32'd0);
        check("bp_no_wen", 32'(wen_n), 32'd0);
        check("bp_still_owned", 32'(s_active), 32'd1);
        fifo_full = 1'b0; req_last = 4'b0010;
        cycle();
        check("bp_release_wen", 32'(s_wen), 32'd1);
        req_valid = '0; req_last = '0;
        cycle();
        check("bp_release_done", 32'(s_done), 32'd1);

        // ---- Truncation: requester 3 offers 20 bytes ----
        do_reset();
        idx = 0; trunc_n = 0; done_n = 0; trunc_at = -1; got.delete();
        for (int c = 0; c < 80; c++) begin
            req_valid = (idx < 20) ? 4'b1000 : 4'b0000;
            req_data  = {8'(idx + 1), 24'h0};
            req_last  = (idx == 19) ? 4'b1000 : 4'b0000;
            cycle();
            if (s_trunc) begin trunc_n++; trunc_at = idx; end
            if (s_active) check("tr_gid", 32'(s_gid), 32'd3);
            if (s_wen) got.push_back(s_wdata);
            if (s_acc[3]) idx++;
            if (s_done) begin done_n++; break; end
        end
        check("tr_trunc_count", 32'(trunc_n), 32'd1);
        check("tr_trunc_at", 32'(trunc_at), 32'(MAXP));
        check("tr_done", 32'(done_n), 32'd1);
        check("tr_bytes", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("tr_byte%0d", i), 32'(got[i]), 32'(i + 1));

        // ---- Stall timeout: requester 0 goes quiet, requester 1 waits ----
        do_reset();
        idx = 0; abort_n = 0; last_xfer_c = -1; abort_c = -1; grant1_c = -1; g1_seen = 0;
        req_data = 32'h0000_7701; req_last = 4'b0010; req_valid = 4'b0011;
        for (int c = 0; c < 200; c++) begin
            req_valid[0] = (idx < 2);
            cycle();
            if (s_acc[0]) begin idx++; last_xfer_c = c; end
            if (s_abort) begin abort_n++; abort_c = c; end
            if (s_active && s_gid == 2'd1 && !g1_seen) begin g1_seen = 1; grant1_c = c; end
            if (s_acc[1]) req_valid[1] = 1'b0;
            if (s_done) break;
        end
        check("st_abort_count", 32'(abort_n), 32'd1);
        // Release edge comes STO cycles after the last transfer edge; the
        // pulse is visible in the cycle following that edge.
        check("st_abort_delay", 32'(abort_c - last_xfer_c), 32'(STO + 1));
        check("st_next_grant", 32'(grant1_c - abort_c), 32'd1);

        // ---- Asynchronous reset during byte 3 of 5 ----
        do_reset();
        idx = 0;
        req_valid = 4'b0001; req_last = '0;
        for (int c = 0; c < 20 && idx < 2; c++) begin
            req_data = {24'h0, 8'(idx + 1)};
            cycle();
            if (s_acc[0]) idx++;
        end
        req_data = 32'h0000_0003;
        #2;
        check("rst_pre_wen", 32'(fifo_wen), 32'd1);
        nReset = 1'b0;
        #1;
        model_reset();
        check("rst_wen", 32'(fifo_wen), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_active", 32'(grant_active), 32'd0);
        check("rst_pulses", 32'({pkt_done, pkt_trunc, pkt_abort}), 32'd0);
        cycle();
        req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'hEE00_00E0;
        nReset = 1'b1;
        cycle();
        check("rst_no_pulse", 32'({s_done, s_trunc, s_abort}), 32'd0);
        cycle();
        check("rst_first_owner", 32'(s_gid), 32'd0);
        check("rst_first_active", 32'(s_active), 32'd1);
        req_valid = '0; req_last = '0;
        repeat (2) cycle();

        // ---- Randomized traffic against the model ----
        verbose = 1'b0;
        do_reset();
        for (int c = 0; c < 3600; c++) begin
            case ((c / 400) % 3)
                0: begin
                    for (int b = 0; b < N; b++) req_valid[b] = ($urandom_range(0, 3) != 0);
                    for (int b = 0; b < N; b++) req_last[b]  = ($urandom_range(0, 3) == 0);
                end
                1: begin
                    for (int b = 0; b < N; b++) req_valid[b] = ($urandom_range(0, 7) == 0);
                    for (int b = 0; b < N; b++) req_last[b]  = ($urandom_range(0, 30) == 0);
                end
                default: begin
                    req_valid = ($urandom_range(0, 99) == 0) ? 4'($urandom) : 4'b0000;
                    req_last  = '0;
                end
            endcase
            req_data  = $urandom;
            fifo_full = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
